// File: rtl/sga_render_controller.sv
// Render sequencer for the Snake Game Arcade playfield: clears the frame buffer,
// draws head and body from the body RAM, then draws the apple, once per start.
module sga_render_controller #(
  parameter int COORD_BITS = 3,
  parameter int IDX_BITS   = 4,
  parameter int MAX_SIZE   = 16
) (
  input  logic                    clock,
  input  logic                    restart,
  input  logic                    start,
  input  logic [IDX_BITS-1:0]     size,
  input  logic [COORD_BITS-1:0]   apple_x,
  input  logic [COORD_BITS-1:0]   apple_y,
  output logic [IDX_BITS-1:0]     seg_addr,
  input  logic [2*COORD_BITS-1:0] seg_data,
  output logic                    fb_we,
  output logic [2*COORD_BITS-1:0] fb_addr,
  output logic [1:0]              fb_data,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              db_state
);

  localparam int ADDR_BITS = 2 * COORD_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_CELL  = '1;
  localparam logic [IDX_BITS:0]    MAX_SIZE_C = (IDX_BITS + 1)'(MAX_SIZE);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CLEAR   = 4'd1,
    BODY_RD = 4'd2,
    BODY_WR = 4'd3,
    APPLE   = 4'd4,
    DONE    = 4'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  cell_q, cell_d;
  logic [IDX_BITS-1:0]   seg_q, seg_d;
  // One bit wider than the size port so MAX_SIZE = 2^IDX_BITS is representable
  logic [IDX_BITS:0]     size_q, size_d;
  logic [COORD_BITS-1:0] apple_x_q, apple_x_d;
  logic [COORD_BITS-1:0] apple_y_q, apple_y_d;
  logic [IDX_BITS:0]     size_ext;

  always_ff @(posedge clock) begin
    if (restart) begin
      state_q   <= IDLE;
      cell_q    <= '0;
      seg_q     <= '0;
      size_q    <= '0;
      apple_x_q <= '0;
      apple_y_q <= '0;
    end else begin
      state_q   <= state_d;
      cell_q    <= cell_d;
      seg_q     <= seg_d;
      size_q    <= size_d;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cell_d    = cell_q;
    seg_d     = seg_q;
    size_d    = size_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    size_ext  = {1'b0, size};
    case (state_q)
      IDLE: begin
        if (start) begin
          size_d    = (size_ext > MAX_SIZE_C) ? MAX_SIZE_C : size_ext;
          apple_x_d = apple_x;
          apple_y_d = apple_y;
          cell_d    = '0;
          seg_d     = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        cell_d = cell_q + 1'b1;
        if (cell_q == LAST_CELL) begin
          state_d = (size_q != '0) ? BODY_RD : APPLE;
        end
      end
      BODY_RD: state_d = BODY_WR;
      BODY_WR: begin
        seg_d   = seg_q + 1'b1;
        state_d = ({1'b0, seg_q} == size_q - 1'b1) ? APPLE : BODY_RD;
      end
      APPLE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register and counters only
  always_comb begin
    seg_addr = '0;
    fb_we    = 1'b0;
    fb_addr  = '0;
    fb_data  = 2'b00;
    done     = 1'b0;
    busy     = (state_q != IDLE);
    db_state = state_q;
    case (state_q)
      CLEAR: begin
        fb_we   = 1'b1;
        fb_addr = cell_q;
      end
      BODY_RD: seg_addr = seg_q;
      BODY_WR: begin
        seg_addr = seg_q;
        fb_we    = 1'b1;
        fb_addr  = seg_data;
        fb_data  = (seg_q == '0) ? 2'b10 : 2'b01;
      end
      APPLE: begin
        fb_we   = 1'b1;
        fb_addr = {apple_y_q, apple_x_q};
        fb_data = 2'b11;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sga_render_controller.sv
// Self-checking bench for sga_render_controller: directed vector table, reset
// sequences and randomized frames checked against a frame-level reference model.
module tb_sga_render_controller;

  localparam int CB   = 3;
  localparam int IB   = 5;
  localparam int MAXS = 16;
  localparam int N    = 64;

  logic          clock;
  logic          restart;
  logic          start;
  logic [IB-1:0] size;
  logic [CB-1:0] apple_x;
  logic [CB-1:0] apple_y;
  logic [IB-1:0] seg_addr;
  logic [5:0]    seg_data;
  logic          fb_we;
  logic [5:0]    fb_addr;
  logic [1:0]    fb_data;
  logic          busy;
  logic          done;
  logic [3:0]    db_state;

  logic [5:0] body_mem [32];

  int n_cmp  = 0;
  int n_fail = 0;

  sga_render_controller #(
    .COORD_BITS(CB),
    .IDX_BITS  (IB),
    .MAX_SIZE  (MAXS)
  ) dut (
    .clock   (clock),
    .restart (restart),
    .start   (start),
    .size    (size),
    .apple_x (apple_x),
    .apple_y (apple_y),
    .seg_addr(seg_addr),
    .seg_data(seg_data),
    .fb_we   (fb_we),
    .fb_addr (fb_addr),
    .fb_data (fb_data),
    .busy    (busy),
    .done    (done),
    .db_state(db_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Body RAM with one-cycle synchronous read
  always @(posedge clock) seg_data <= body_mem[seg_addr];

  task automatic check_output(input string name, input int actual, input int required);
    n_cmp++;
    if (actual != required) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Expected state code and segment address for cycle k of a render with S segments
  function automatic int exp_state(input int k, input int s);
    if (k <= N) return 1;
    if (k <= N + 2 * s) return ((k - N - 1) % 2 == 0) ? 2 : 3;
    if (k == N + 2 * s + 1) return 4;
    if (k == N + 2 * s + 2) return 5;
    return 0;
  endfunction

  function automatic int exp_seg(input int k, input int s);
    if (k > N && k <= N + 2 * s) return (k - N - 1) / 2;
    return 0;
  endfunction

  task automatic apply_stimulus(input int sz, input int ax, input int ay);
    @(negedge clock);
    start   = 1'b1;
    size    = IB'(sz);
    apple_x = CB'(ax);
    apple_y = CB'(ay);
  endtask

  task automatic run_frame(input string name, input int sz, input int ax, input int ay,
                           input int g1, input int g2, input int tbl_done, input int tbl_apple);
    int s_cl, e_done, cycle, done_cycle, bad_state, bad_busy, bad_seq, bad_fb, last_addr;
    int exp_wr[$];
    int act_wr[$];
    int exp_fb[64];
    int act_fb[64];
    s_cl       = (sz > MAXS) ? MAXS : sz;
    e_done     = N + 2 * s_cl + 2;
    done_cycle = -1;
    bad_state  = 0;
    bad_busy   = 0;
    bad_seq    = 0;
    bad_fb     = 0;
    for (int c = 0; c < N; c++) begin
      exp_wr.push_back(c * 4);
      exp_fb[c] = 0;
      act_fb[c] = 0;
    end
    for (int i = 0; i < s_cl; i++) begin
      exp_wr.push_back(int'(body_mem[i]) * 4 + ((i == 0) ? 2 : 1));
      exp_fb[int'(body_mem[i])] = (i == 0) ? 2 : 1;
    end
    exp_wr.push_back((ay * 8 + ax) * 4 + 3);
    exp_fb[ay * 8 + ax] = 3;

    apply_stimulus(sz, ax, ay);
    @(posedge clock);
    #1;
    start   = 1'b0;
    size    = IB'($urandom);
    apple_x = CB'($urandom);
    apple_y = CB'($urandom);
    cycle   = 0;
    for (int k = 0; k < 200; k++) begin
      cycle++;
      if (int'(db_state) != exp_state(cycle, s_cl) || int'(seg_addr) != exp_seg(cycle, s_cl))
        bad_state++;
      if (!busy) bad_busy++;
      if (fb_we) act_wr.push_back(int'(fb_addr) * 4 + int'(fb_data));
      if (cycle == g1 || cycle == g2) begin
        start   = 1'b1;
        size    = IB'($urandom);
        apple_x = CB'($urandom);
        apple_y = CB'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cycle = cycle;
        break;
      end
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    @(posedge clock);
    #1;
    check_output({name, " idle_after"}, int'(db_state) + int'(busy) + int'(done) + int'(fb_we), 0);
    check_output({name, " done_cycle"}, done_cycle, e_done);
    if (tbl_done >= 0) check_output({name, " table_done"}, done_cycle, tbl_done);
    check_output({name, " write_count"}, act_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++)
      if (i >= act_wr.size() || act_wr[i] != exp_wr[i]) bad_seq++;
    check_output({name, " write_seq_bad"}, bad_seq, 0);
    last_addr = (act_wr.size() > 0) ? act_wr[act_wr.size() - 1] / 4 : -1;
    if (tbl_apple >= 0) check_output({name, " last_write_addr"}, last_addr, tbl_apple);
    foreach (act_wr[i]) act_fb[act_wr[i] / 4] = act_wr[i] % 4;
    for (int c = 0; c < N; c++) if (act_fb[c] != exp_fb[c]) bad_fb++;
    check_output({name, " frame_cells_bad"}, bad_fb, 0);
    check_output({name, " state_trace_bad"}, bad_state, 0);
    check_output({name, " busy_low_cycles"}, bad_busy, 0);
  endtask

  typedef struct {
    string name;
    int    sz;
    int    ax;
    int    ay;
    int    g1;
    int    g2;
    int    exp_done;
    int    exp_apple;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int found, extra_done;
    restart = 1'b1;
    start   = 1'b1;
    size    = 5'd3;
    apple_x = '0;
    apple_y = '0;
    foreach (body_mem[i]) body_mem[i] = 6'($urandom);

    // Reset held with start asserted
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #1;
      check_output("reset_outputs", int'(fb_we) + int'(fb_addr) + int'(fb_data) + int'(seg_addr)
                   + int'(busy) + int'(done), 0);
      check_output("reset_state", int'(db_state), 0);
    end
    start = 1'b0;
    @(negedge clock);
    restart = 1'b0;
    @(posedge clock);
    #1;
    check_output("post_reset_idle", int'(db_state) + int'(busy), 0);

    vecs[0] = '{"clear_only", 0, 5, 2, 0, 0, 66, 21};
    vecs[1] = '{"normal", 3, 6, 6, 0, 0, 72, 54};
    vecs[2] = '{"clamp_overlap", 20, 3, 3, 0, 0, 98, 27};
    vecs[3] = '{"start_busy", 3, 6, 6, 10, 68, 72, 54};
    for (int v = 0; v < 4; v++) begin
      foreach (body_mem[i]) body_mem[i] = 6'($urandom);
      body_mem[0] = 6'd27;
      body_mem[1] = 6'd26;
      body_mem[2] = 6'd25;
      if (v == 2) begin
        body_mem[4] = 6'd27;
        body_mem[7] = 6'd26;
      end
      run_frame(vecs[v].name, vecs[v].sz, vecs[v].ax, vecs[v].ay,
                vecs[v].g1, vecs[v].g2, vecs[v].exp_done, vecs[v].exp_apple);
    end

    // Reset in the middle of a body write
    apply_stimulus(4, 1, 1);
    @(posedge clock);
    #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 200; k++) begin
      if (db_state == 4'd3) begin
        found = 1;
        break;
      end
      @(posedge clock);
      #1;
    end
    check_output("midreset_reached_body_wr", found, 1);
    restart = 1'b1;
    @(posedge clock);
    #1;
    restart = 1'b0;
    check_output("midreset_state", int'(db_state), 0);
    check_output("midreset_fb_we", int'(fb_we), 0);
    check_output("midreset_busy_done", int'(busy) + int'(done), 0);
    extra_done = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clock);
      #1;
      if (done || busy) extra_done++;
    end
    check_output("midreset_no_activity", extra_done, 0);
    run_frame("after_reset", 3, 6, 6, 0, 0, 72, 54);

    // Randomized frames against the reference model
    for (int r = 0; r < 20; r++) begin
      int sz, s_cl, g1, g2;
      foreach (body_mem[i]) body_mem[i] = 6'($urandom);
      sz   = $urandom_range(0, 31);
      s_cl = (sz > MAXS) ? MAXS : sz;
      g1   = $urandom_range(1, N + 2 * s_cl + 1);
      g2   = $urandom_range(1, N + 2 * s_cl + 1);
      run_frame($sformatf("rand%0d", r), sz, $urandom_range(0, 7), $urandom_range(0, 7),
                g1, g2, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
